hilo_ctrl: RTL
==============

Name: hilo_ctrl

Overview:
- Sequencer for the multiply/divide unit of the ALU (alufunc 1100..1111) and owner of the architectural HI/LO registers.
- Accepts a mult/div issue from the execute stage and latches the operands so the ALU's combinational mult/div path is held stable. It times that path as a multicycle path, then captures result/HI into LO/HI.
- Provides busy/stall, MFHI/MFLO read, MTHI/MTLO write and divide-by-zero reporting to the pipeline.

Parameters:
- MUL_CYCLES, 4, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 16, busy cycles for DIV/DIVU (>=1)
- CW, 5, counter width; must satisfy 2^CW > max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue request, one-cycle pulse
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  operand a, the divisor for DIV/DIVU
- src_b  in  32  operand b, the dividend for DIV/DIVU
- cancel  in  1  pipeline flush; aborts an in-flight op
- mthi  in  1  write HI from wdata
- mtlo  in  1  write LO from wdata
- wdata  in  32  MTHI/MTLO data
- alu_a  out  32  registered operand to ALU dataa
- alu_b  out  32  registered operand to ALU datab
- alu_func  out  4  {2'b11, op_reg} to ALU alufunc
- alu_result  in  32  ALU result (LO / quotient)
- alu_hi  in  32  ALU HI (upper product / remainder)
- alu_overflow  in  1  ALU overflow; for div this means divisor==0
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  op in flight; the pipeline stalls MFHI/MFLO/MTHI/MTLO/start while high
- done  out  1  one-cycle pulse after HI/LO capture
- dz  out  1  sticky divide-by-zero flag for the last op

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, alu_a=0, alu_b=0, op_reg=00 (alu_func=1100), count=0, state=IDLE, busy=0, done=0, dz=0.
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE, start=1 at edge E0:
  - alu_a<=src_a, alu_b<=src_b, op_reg<=op, dz<=0.
  - count<=N-1, where N=MUL_CYCLES if op[1]=0, else DIV_CYCLES.
  - state<=RUN.
- RUN, count!=0: count decrements each edge. Operands and alu_func are held constant.
- RUN, count==0 at an edge:
  - If op_reg[1]=1 and alu_overflow=1: hi/lo unchanged, dz<=1.
  - Otherwise: lo<=alu_result, hi<=alu_hi.
  - In both cases: state<=IDLE, done<=1 for exactly one cycle.
- Latency: busy is high for exactly N cycles after E0. done is high in cycle N+1 relative to E0. New hi/lo is visible in that same cycle.
- Back-to-back: start is legal in the done cycle, since state is IDLE.
- busy = (state==RUN), combinational from state.
- start while busy: ignored. The pipeline guarantees this never happens; an assertion flags it.
- mthi/mtlo while busy: ignored (stalled upstream); an assertion flags it.
- mthi/mtlo in IDLE: the register is written at the edge. Both may be asserted together; HI and LO both take wdata.
- start together with mthi/mtlo in IDLE: the start is taken, and the mthi/mtlo write is also applied at that edge. The later capture overwrites it.
- cancel in RUN: state<=IDLE, count<=0, no hi/lo update, no done, dz unchanged.
- cancel in IDLE with start: start is suppressed.
- cancel has priority over count==0 capture in the same cycle.
- Reset mid-op: immediate return to reset values; no capture.
- Arithmetic is entirely in the ALU; this block does no arithmetic beyond the CW-bit down-counter, which never wraps (loads only in IDLE).

Decomposition:
- Shared package holds:
  - ALU function constants ALU_MULT=4'b1100, ALU_MULTU=4'b1101, ALU_DIV=4'b1110, ALU_DIVU=4'b1111.
  - The op encoding.
  - State enum IDLE/RUN.
- No sub-module: the counter and FSM sit in one always block, and HI/LO in another.
- The bench instantiates hilo_ctrl together with the real alu.

Test Plan:
- MULT src_a=-3 (FFFFFFFD), src_b=7, MUL_CYCLES=4 -> busy high 4 cycles, done in cycle 5, hi=FFFFFFFF, lo=FFFFFFEB, dz=0.
- DIVU src_a=5, src_b=23, DIV_CYCLES=16 -> busy 16 cycles, lo=4, hi=3; then start DIV in the done cycle with src_a=2, src_b=-7 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV src_a=0, src_b=100 with hi=AAAA_AAAA, lo=5555_5555 preset via MTHI/MTLO -> dz=1, hi/lo unchanged, done pulses once.
- MULTU FFFFFFFF*FFFFFFFF with cancel at cycle 2 -> busy drops next cycle, no done, hi/lo keep prior values; a following MULTU completes to hi=FFFFFFFE, lo=00000001.
- Async rst asserted mid-DIV (cycle 8, between clock edges) -> busy, done, dz, hi, lo read 0 immediately; no capture after rst release.
- mthi=1 and mtlo=1 simultaneously, wdata=12345678, in IDLE -> hi=lo=12345678 next cycle; start+mtlo in the same cycle -> MULT result overwrites lo at capture.

Source files
------------

// File: rtl/hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_ctrl_pkg
//  Purpose  : Shared definitions for the multiply/divide sequencer.
//             - ALU function codes of the mult/div group (alufunc 1100..1111)
//             - Mult/div op encoding as carried on the 'op' issue port
//             - Sequencer state encoding
//             - Helper that maps an op to its ALU function code
//  Revision : 1.0  initial release
// ============================================================================
package hilo_ctrl_pkg;

  // ALU function codes of the multiply/divide group.
  localparam logic [3:0] ALU_MULT  = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_DIVU  = 4'b1111;

  // Op encoding on the issue port. Bit 1 selects divide, bit 0 selects
  // unsigned; the low two bits of the ALU function code are the op itself.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // The mult/div group occupies the top quarter of the ALU function space,
  // so the function code is the group prefix followed by the op.
  function automatic logic [3:0] alu_func_of(input logic [1:0] op);
    return {ALU_MULT[3:2], op};
  endfunction

  // Divide ops are the ones whose ALU overflow flag means "divisor is zero".
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage : hilo_ctrl_pkg
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_ctrl
//  Purpose  : Sequencer for the ALU multiply/divide path and owner of the
//             architectural HI/LO registers. An issued op has its operands
//             latched so the ALU's combinational mult/div path stays stable;
//             the path is then timed as a multicycle path (MUL_CYCLES or
//             DIV_CYCLES) before its result is captured into LO/HI.
//
//  Ports    :
//    clk           in   rising-edge clock
//    rst           in   asynchronous active-high reset
//    start         in   issue request (one-cycle pulse)
//    op[1:0]       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//    src_a[31:0]   in   operand a (divisor for DIV/DIVU)
//    src_b[31:0]   in   operand b (dividend for DIV/DIVU)
//    cancel        in   pipeline flush, aborts an in-flight op
//    mthi / mtlo   in   write HI / LO from wdata
//    wdata[31:0]   in   MTHI/MTLO data
//    alu_a/alu_b   out  registered operands to the ALU
//    alu_func[3:0] out  ALU function code {2'b11, op}
//    alu_result    in   ALU low result / quotient
//    alu_hi        in   ALU high result / remainder
//    alu_overflow  in   ALU overflow; for divides, divisor == 0
//    hi / lo       out  architectural HI / LO
//    busy          out  op in flight
//    done          out  one-cycle pulse after HI/LO capture
//    dz            out  sticky divide-by-zero flag for the last op
//
//  Revision : 1.0  initial release
// ============================================================================
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int CW         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_func,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  input  logic        alu_overflow,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  // The counter holds "edges remaining before capture", so it is loaded
  // with N-1: the capture edge is the one that finds the counter at zero.
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Sequencer state, counter, operand latch and status flags
  // --------------------------------------------------------------------------
  logic [0:0]    state_q,  state_d;
  logic [CW-1:0] count_q,  count_d;
  logic [31:0]   alu_a_q,  alu_a_d;
  logic [31:0]   alu_b_q,  alu_b_d;
  logic [1:0]    op_q,     op_d;
  logic          dz_q,     dz_d;
  logic          done_q,   done_d;

  // Asserted for the single edge at which the ALU result is written to HI/LO.
  logic          capture;

  always_comb begin : fsm_comb
    state_d = state_q;
    count_d = count_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    op_d    = op_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flush arriving with the issue squashes the issue itself.
        if (start && !cancel) begin
          alu_a_d = src_a;
          alu_b_d = src_b;
          op_d    = op;
          dz_d    = 1'b0;
          count_d = op_is_div(op) ? DIV_LOAD : MUL_LOAD;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Cancel wins over a capture due on the same edge.
        if (cancel) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // A divide by zero leaves HI/LO untouched and only raises dz.
          if (op_is_div(op_q) && alu_overflow) begin
            dz_d = 1'b1;
          end else begin
            capture = 1'b1;
          end
        end else begin
          count_d = count_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_seq
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      op_q    <= OP_MULT;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Architectural HI/LO
  // --------------------------------------------------------------------------
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin : hilo_comb
    hi_d = hi_q;
    lo_d = lo_q;
    // Moves are only honoured while idle; the pipeline stalls them otherwise.
    // This includes the issue edge, where the move lands first and is later
    // overwritten by the capture.
    if (state_q == ST_IDLE) begin
      if (mthi) hi_d = wdata;
      if (mtlo) lo_d = wdata;
    end
    if (capture) begin
      hi_d = alu_hi;
      lo_d = alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : hilo_seq
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_of(op_q);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign dz       = dz_q;

  // --------------------------------------------------------------------------
  // Pipeline contract: no issue and no HI/LO move while an op is in flight.
  // --------------------------------------------------------------------------
  a_no_start_when_busy : assert property (
    @(posedge clk) disable iff (rst) !(start && busy)
  );

  a_no_move_when_busy : assert property (
    @(posedge clk) disable iff (rst) !((mthi || mtlo) && busy)
  );

endmodule : hilo_ctrl
`default_nettype wire
